// File: rtl/fetch_stage_if.sv
// fetch_stage_if
//   Bundles the fetch stage's control inputs from decode, its instruction
//   memory request/response pair and the IF/ID pipeline register.
//   master : the fetch stage itself
//            in  BranchControlSignal, BranchTarget, pcHOLD, imem_ack, imem_rdata
//            out imem_req, imem_addr, IFIDReg
//   slave  : the environment (decode + instruction memory), directions mirrored
interface fetch_stage_if;
  logic        BranchControlSignal;
  logic [31:0] BranchTarget;
  logic        pcHOLD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [63:0] IFIDReg;

  modport master (
    input  BranchControlSignal, BranchTarget, pcHOLD, imem_ack, imem_rdata,
    output imem_req, imem_addr, IFIDReg
  );

  modport slave (
    output BranchControlSignal, BranchTarget, pcHOLD, imem_ack, imem_rdata,
    input  imem_req, imem_addr, IFIDReg
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction fetch for a 5-stage pipeline. Issues one outstanding request
//   at a time to an instruction memory with variable latency, writes
//   {instruction, PC+4} into IFIDReg, honours load-use stalls (pcHOLD) and
//   squashes the in-flight fetch on a taken branch.
//   Ports:
//     clk   - single clock, all state on rising edge
//     rst_n - asynchronous active-low reset
//     bus   - fetch_stage_if.master (decode controls, imem req/ack, IFIDReg)
//   Parameters:
//     RESET_PC  - first fetch address after reset
//     NOP_INSTR - instruction word used for bubbles
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HELD = 2'd2
  } state_t;

  state_t      r_state, w_state;
  logic [31:0] r_pc, w_pc;
  logic        r_kill, w_kill;
  logic [31:0] r_buf, w_buf;
  logic [63:0] r_ifid, w_ifid;
  logic        r_req, w_req;
  logic [31:0] r_addr, w_addr;

  logic [31:0] w_pc_inc;
  logic [63:0] w_bubble;
  logic        w_branch;

  // Natural 32-bit overflow gives the required modulo-2^32 wrap.
  assign w_pc_inc = r_pc + 32'd4;
  assign w_bubble = {NOP_INSTR, 32'h0000_0000};
  // A stall freezes everything, so a branch only counts when not stalled.
  assign w_branch = bus.BranchControlSignal & ~bus.pcHOLD;

  // Next-state and next-register computation for the fetch FSM.
  always_comb begin
    w_state = r_state;
    w_pc    = r_pc;
    w_kill  = r_kill;
    w_buf   = r_buf;
    w_ifid  = r_ifid;
    w_addr  = r_addr;

    case (r_state)
      S_IDLE: begin
        w_state = S_REQ;
        if (w_branch) begin
          w_pc   = bus.BranchTarget;
          w_addr = bus.BranchTarget;
        end else begin
          w_addr = r_pc;
        end
        if (!bus.pcHOLD) begin
          w_ifid = w_bubble;
        end else begin
          w_ifid = r_ifid;
        end
      end

      S_REQ: begin
        if (bus.imem_ack) begin
          if (r_kill || w_branch) begin
            // Returned word belongs to a squashed path: drop it and
            // refetch from the (possibly just redirected) pc.
            w_kill = 1'b0;
            if (w_branch) begin
              w_pc   = bus.BranchTarget;
              w_addr = bus.BranchTarget;
            end else begin
              w_addr = r_pc;
            end
            if (!bus.pcHOLD) begin
              w_ifid = w_bubble;
            end else begin
              w_ifid = r_ifid;
            end
          end else if (bus.pcHOLD) begin
            // Decode is stalled: park the word until it can take it.
            w_buf   = bus.imem_rdata;
            w_state = S_HELD;
          end else begin
            w_ifid = {bus.imem_rdata, w_pc_inc};
            w_pc   = w_pc_inc;
            w_addr = w_pc_inc;
          end
        end else begin
          // Request still outstanding; the address must not move, so a
          // branch only retargets pc and marks the pending data as dead.
          if (w_branch) begin
            w_pc   = bus.BranchTarget;
            w_kill = 1'b1;
            w_ifid = w_bubble;
          end else if (!bus.pcHOLD) begin
            w_ifid = w_bubble;
          end else begin
            w_ifid = r_ifid;
          end
        end
      end

      S_HELD: begin
        if (w_branch) begin
          w_pc    = bus.BranchTarget;
          w_addr  = bus.BranchTarget;
          w_buf   = 32'h0000_0000;
          w_ifid  = w_bubble;
          w_state = S_REQ;
        end else if (!bus.pcHOLD) begin
          w_ifid  = {r_buf, w_pc_inc};
          w_pc    = w_pc_inc;
          w_addr  = w_pc_inc;
          w_state = S_REQ;
        end else begin
          w_state = S_HELD;
        end
      end

      default: begin
        w_state = S_IDLE;
        w_pc    = RESET_PC;
        w_kill  = 1'b0;
        w_addr  = RESET_PC;
        w_ifid  = w_bubble;
      end
    endcase

    w_req = (w_state == S_REQ);
  end

  // State and output registers; reset abandons any outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_kill  <= 1'b0;
      r_buf   <= 32'h0000_0000;
      r_ifid  <= {NOP_INSTR, 32'h0000_0000};
      r_req   <= 1'b0;
      r_addr  <= RESET_PC;
    end else begin
      r_state <= w_state;
      r_pc    <= w_pc;
      r_kill  <= w_kill;
      r_buf   <= w_buf;
      r_ifid  <= w_ifid;
      r_req   <= w_req;
      r_addr  <= w_addr;
    end
  end

  assign bus.imem_req  = r_req;
  assign bus.imem_addr = r_addr;
  assign bus.IFIDReg   = r_ifid;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Scoreboard bench for fetch_stage. A scripted decode/memory driver pushes
//   the IFIDReg value each cycle's stimulus must produce; the value is popped
//   and compared after the clock edge. A second instance with
//   RESET_PC = 32'hFFFF_FFFC runs against a zero-wait memory to cover the
//   pc+4 wrap.
module tb_fetch_stage;

  logic clk;
  logic rst_n;

  fetch_stage_if if1 ();
  fetch_stage_if if2 ();

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.master)
  );

  fetch_stage #(
    .RESET_PC  (32'hFFFF_FFFC),
    .NOP_INSTR (32'h0000_0000)
  ) dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if2.master)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  logic [63:0] sb_q[$];
  int          step_idx = 0;

  localparam logic [63:0] BUBBLE = 64'h0;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return 32'h2008_0001 + (a >> 2);
  endfunction

  // Zero-wait memory for the wrap instance: ack in every requesting cycle.
  assign if2.BranchControlSignal = 1'b0;
  assign if2.BranchTarget        = 32'h0000_0000;
  assign if2.pcHOLD              = 1'b0;
  assign if2.imem_ack            = if2.imem_req;
  assign if2.imem_rdata          = memw(if2.imem_addr);

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge: check request outputs, drive one cycle of stimulus,
  // push the IFIDReg it must produce, then compare after the edge.
  task automatic step(input logic br, input logic [31:0] tgt, input logic hold,
                      input logic ack, input logic exp_req, input logic [31:0] exp_addr,
                      input logic [63:0] exp_ifid);
    logic [63:0] e;
    check($sformatf("req%0d", step_idx), {63'h0, if1.imem_req}, {63'h0, exp_req});
    if (exp_req) begin
      check($sformatf("addr%0d", step_idx), {32'h0, if1.imem_addr}, {32'h0, exp_addr});
    end
    if1.BranchControlSignal = br;
    if1.BranchTarget        = tgt;
    if1.pcHOLD              = hold;
    if1.imem_ack            = ack;
    if1.imem_rdata          = ack ? memw(exp_addr) : 32'hDEAD_BEEF;
    sb_q.push_back(exp_ifid);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check($sformatf("sb_empty%0d", step_idx), 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      check($sformatf("ifid%0d", step_idx), if1.IFIDReg, e);
    end
    step_idx++;
    @(negedge clk);
  endtask

  initial begin
    rst_n                   = 1'b0;
    if1.BranchControlSignal = 1'b0;
    if1.BranchTarget        = 32'h0;
    if1.pcHOLD              = 1'b0;
    if1.imem_ack            = 1'b0;
    if1.imem_rdata          = 32'h0;

    #1;
    check("rst_req",  {63'h0, if1.imem_req}, 64'd0);
    check("rst_addr", {32'h0, if1.imem_addr}, 64'h0);
    check("rst_ifid", if1.IFIDReg, BUBBLE);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle cycle, then zero-wait fetches of 0 and 4.
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,  BUBBLE);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0,  {memw(32'h0), 32'h4});
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h4,  {memw(32'h4), 32'h8});
    // Stall for 3 cycles coincident with the ack of 0x8.
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h8,  {memw(32'h4), 32'h8});
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h8,  {memw(32'h4), 32'h8});
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h8,  {memw(32'h4), 32'h8});
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h8,  {memw(32'h8), 32'hC});
    // Two wait states at 0xC.
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hC,  BUBBLE);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hC,  BUBBLE);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hC,  {memw(32'hC), 32'h10});
    // Branch to 0x40 while 0x10 is pending; 0x10 acked two cycles later.
    step(1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 32'h10, BUBBLE);
    step(1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h10, BUBBLE);
    step(1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h10, BUBBLE);
    step(1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h40, {memw(32'h40), 32'h44});
    // Two branches while killed: only the latest target is fetched.
    step(1'b1, 32'h80,  1'b0, 1'b0, 1'b1, 32'h44, BUBBLE);
    step(1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 32'h44, BUBBLE);
    step(1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h44, BUBBLE);
    step(1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h100, {memw(32'h100), 32'h104});
    // Branch coincident with ack: word dropped, target fetched next.
    step(1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 32'h104, BUBBLE);
    step(1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h200, {memw(32'h200), 32'h204});
    // Branch together with pcHOLD is ignored.
    step(1'b1, 32'h300, 1'b1, 1'b0, 1'b1, 32'h204, {memw(32'h200), 32'h204});
    step(1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h204, {memw(32'h204), 32'h208});
    // Branch out of HELD discards the buffered word.
    step(1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h208, {memw(32'h204), 32'h208});
    step(1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 32'h208, BUBBLE);
    step(1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h400, {memw(32'h400), 32'h404});

    // Asynchronous reset in the middle of an outstanding request.
    if1.BranchControlSignal = 1'b0;
    if1.pcHOLD              = 1'b0;
    if1.imem_ack            = 1'b0;
    check("mid_req",  {63'h0, if1.imem_req}, 64'd1);
    check("mid_addr", {32'h0, if1.imem_addr}, {32'h0, 32'h404});
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req",   {63'h0, if1.imem_req}, 64'd0);
    check("arst_addr",  {32'h0, if1.imem_addr}, 64'h0);
    check("arst_ifid",  if1.IFIDReg, BUBBLE);
    check("arst2_addr", {32'h0, if2.imem_addr}, {32'h0, 32'hFFFF_FFFC});
    check("arst2_ifid", if2.IFIDReg, BUBBLE);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Post-reset: both instances idle one cycle, then request RESET_PC.
    check("post_idle_req",  {63'h0, if1.imem_req}, 64'd0);
    check("post_idle2_req", {63'h0, if2.imem_req}, 64'd0);
    @(negedge clk);
    check("post_req",    {63'h0, if1.imem_req}, 64'd1);
    check("post_addr",   {32'h0, if1.imem_addr}, 64'h0);
    check("wrap_req",    {63'h0, if2.imem_req}, 64'd1);
    check("wrap_addr0",  {32'h0, if2.imem_addr}, {32'h0, 32'hFFFF_FFFC});
    @(negedge clk);
    check("wrap_ifid0",  if2.IFIDReg, {memw(32'hFFFF_FFFC), 32'h0});
    check("wrap_addr1",  {32'h0, if2.imem_addr}, 64'h0);
    @(negedge clk);
    check("wrap_ifid1",  if2.IFIDReg, {memw(32'h0), 32'h4});
    // dut has been waiting at RESET_PC with no ack; complete that fetch.
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, {memw(32'h0), 32'h4});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset, SHALL be provided.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000 (sll $0,$0,0), bubble instruction, SHALL be provided.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 BranchControlSignal  input  1  taken branch resolved in decode this cycle.
REQ-006 BranchTarget  input  32  redirect address, valid when BranchControlSignal=1.
REQ-007 pcHOLD  input  1  load-use stall from decode; freezes PC and IFIDReg.
REQ-008 imem_req  output  1  instruction memory request, held until imem_ack.
REQ-009 imem_addr  output  32  word address of the outstanding request, stable while imem_req=1.
REQ-010 imem_ack  input  1  read data valid this cycle, 1 or more cycles after request.
REQ-011 imem_rdata  input  32  instruction word, sampled only when imem_ack=1.
REQ-012 IFIDReg  output  64  registered {instruction[63:32], PC+4[31:0]} consumed by decode.

Function
REQ-013 The block SHALL hold state IDLE, REQ or HELD, a pc register, a kill flag and a 32-bit hold buffer.
REQ-014 IDLE SHALL last exactly one cycle after reset release, imem_req=0, then go to REQ with imem_addr=pc.
REQ-015 In REQ, imem_req SHALL be 1 and imem_addr SHALL not change until the cycle imem_ack=1.
REQ-016 REQ, ack=1, kill=0, pcHOLD=0, no branch: IFIDReg <= {imem_rdata, pc+4}; pc <= pc+4; next request to pc+4 issued the following cycle with no idle gap.
REQ-017 REQ, ack=0, pcHOLD=0, no branch: IFIDReg <= {NOP_INSTR, 32'h0} (bubble).
REQ-018 pcHOLD=1 SHALL leave IFIDReg and pc unchanged in every state.
REQ-019 REQ, ack=1, kill=0, pcHOLD=1: imem_rdata SHALL be captured into the hold buffer, state -> HELD, imem_req=0.
REQ-020 HELD, pcHOLD=0, no branch: IFIDReg <= {buffer, pc+4}; pc <= pc+4; state -> REQ.
REQ-021 pcHOLD has priority: BranchControlSignal SHALL be ignored while pcHOLD=1.
REQ-022 Branch with pcHOLD=0 in any state: pc <= BranchTarget; IFIDReg <= {NOP_INSTR, 32'h0}; a HELD buffer is discarded and state -> REQ.
REQ-023 Branch in REQ with ack=1 the same cycle: returned word SHALL be dropped; next request to BranchTarget the following cycle.
REQ-024 Branch in REQ with ack=0: kill SHALL be set; request to the old address stays asserted until ack; that data is dropped (bubble), kill cleared, next request to current pc.
REQ-025 A further branch while kill=1 SHALL update pc only; kill remains set; only the latest target is fetched.
REQ-026 The pc+4 increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-027 No instruction SHALL ever be written to IFIDReg twice or skipped, except on squash by branch.

Reset
REQ-028 rst_n=0 SHALL immediately force: state IDLE, pc=RESET_PC, kill=0, imem_req=0, imem_addr=RESET_PC, IFIDReg={NOP_INSTR, 32'h0}, buffer=0.
REQ-029 Reset asserted mid-request SHALL abandon the request; after release the first request SHALL go to RESET_PC.

Verification
REQ-030 Zero-wait memory (ack one cycle after req), words 0x20080001.. at 0,4,8 -> IFIDReg {0x20080001,0x4},{..,0x8},{..,0xC} on consecutive fetch-completion edges.
REQ-031 Memory with 2 wait states -> bubbles {0,0} on non-ack cycles, imem_addr stable, instructions in order.
REQ-032 pcHOLD=1 for 3 cycles coincident with ack of word at 0x8 -> IFIDReg frozen, state HELD, after release IFIDReg={word@0x8, 0xC}.
REQ-033 Branch to 0x40 while request to 0x10 pending (ack 2 cycles later) -> IFIDReg bubble, word@0x10 dropped, next imem_addr=0x40, IFIDReg {word@0x40,0x44}.
REQ-034 Branch and pcHOLD both 1 -> branch ignored, pc unchanged; RESET_PC=32'hFFFF_FFFC -> second fetch at 0x0.
REQ-035 rst_n pulsed low during outstanding request -> outputs at reset values asynchronously, first post-reset imem_addr=RESET_PC.
